// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode/funct and select encodings for the multicycle MIPS control unit
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_R_EXEC,
    S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JR
  } state_t;
  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_SLT} alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;
  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;
  localparam logic [1:0] PC_ALU   = 2'b00;
  localparam logic [1:0] PC_JMP   = 2'b01;
  localparam logic [1:0] PC_OUT   = 2'b10;
  localparam logic [1:0] PC_REG   = 2'b11;
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps ALUOp and funct to the datapath alu_ctrl encoding
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_t     i_alu_op,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alu_ctrl
);
  logic [2:0] w_fn_ctrl;
  assign w_fn_ctrl = (i_funct == FN_SUB) ? ALU_SUB :
                     (i_funct == FN_AND) ? ALU_AND :
                     (i_funct == FN_OR)  ? ALU_OR  :
                     (i_funct == FN_SLT) ? ALU_SLT : ALU_ADD;
  assign o_alu_ctrl = (i_alu_op == AOP_SUB)   ? ALU_SUB :
                      (i_alu_op == AOP_SLT)   ? ALU_SLT :
                      (i_alu_op == AOP_FUNCT) ? w_fn_ctrl : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS control FSM driving datapath selects, enables and memory strobes
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic [1:0]  reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  pc_src,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        IorD,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write
);
  state_t     r_state, w_next;
  alu_op_t    w_alu_op;
  logic [5:0] w_op, w_fn;
  logic       w_unused;
  assign w_op = inst[31:26];
  assign w_fn = inst[5:0];
  assign w_unused = ^inst[25:6];
  always_ff @(posedge clk)
    r_state <= rst ? S_FETCH : w_next;
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE:   w_next = (w_op == OP_LW || w_op == OP_SW)     ? S_MEM_ADDR :
                           (w_op == OP_RTYPE)                   ? ((w_fn == FN_JR) ? S_JR : S_R_EXEC) :
                           (w_op == OP_ADDI || w_op == OP_SLTI) ? S_I_EXEC :
                           (w_op == OP_BEQ)                     ? S_BRANCH :
                           (w_op == OP_J || w_op == OP_JAL)     ? S_JUMP : S_FETCH;
      S_MEM_ADDR: w_next = (w_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: w_next = S_MEM_WB;
      S_R_EXEC:   w_next = S_R_WB;
      S_I_EXEC:   w_next = S_I_WB;
      default:    w_next = S_FETCH;
    endcase
  end
  // Reset overrides every state so no write enable can leak through in a reset cycle
  always_comb begin
    reg_dst = RD_RT;
    mem_to_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    w_alu_op = AOP_ADD;
    pc_src = PC_ALU;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    IorD = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        alu_src_b = SRCB_4;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = SRCB_BR;
        reg_write = (w_op == OP_JAL);
        reg_dst = (w_op == OP_JAL) ? RD_RA : RD_RT;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        IorD = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        IorD = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        w_alu_op = AOP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst = RD_RD;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_alu_op = (w_op == OP_SLTI) ? AOP_SLT : AOP_ADD;
      end
      S_I_WB:     reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        w_alu_op = AOP_SUB;
        pc_src = PC_OUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_src = PC_JMP;
        pc_write = 1'b1;
      end
      S_JR: begin
        pc_src = PC_REG;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      reg_dst = RD_RT;
      mem_to_reg = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = SRCB_B;
      w_alu_op = AOP_ADD;
      pc_src = PC_ALU;
      pc_write = 1'b0;
      pc_write_cond = 1'b0;
      IorD = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
    end
  end
  alu_decoder u_alu_decoder (
    .i_alu_op   (w_alu_op),
    .i_funct    (w_fn),
    .o_alu_ctrl (alu_ctrl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench checking per-cycle control words of multicycle_controller
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'h8C220004;
  logic [1:0]  reg_dst, alu_src_b, pc_src;
  logic [2:0]  alu_ctrl;
  logic        mem_to_reg, alu_src_a, pc_write, pc_write_cond, IorD, ir_write, reg_write, mem_read, mem_write;
  logic [17:0] w_obs;
  logic [17:0] sbq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SUB = 3'b110, A_SLT = 3'b111;
  multicycle_controller dut (
    .clk           (clk),
    .rst           (rst),
    .inst          (inst),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_ctrl      (alu_ctrl),
    .pc_src        (pc_src),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .IorD          (IorD),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write)
  );
  always #5 clk = ~clk;
  assign w_obs = {reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
                  pc_write, pc_write_cond, IorD, ir_write, reg_write, mem_read, mem_write};
  function automatic logic [17:0] cw(input logic [1:0] rd, input logic m2r, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] ac, input logic [1:0] ps,
                                     input logic pw, input logic pwc, input logic iord, input logic irw,
                                     input logic rw, input logic mr, input logic mw);
    return {rd, m2r, sa, sb, ac, ps, pw, pwc, iord, irw, rw, mr, mw};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [17:0] w);
    sbq.push_back(w);
  endtask
  // One sampled cycle: pop the expected control word and check the exclusivity invariants
  task automatic step(input string tag);
    logic [17:0] e;
    @(negedge clk);
    if (sbq.size() == 0) chk({tag, "_underflow"}, 32'd1, 32'd0);
    else begin
      e = sbq.pop_front();
      chk(tag, {14'd0, w_obs}, {14'd0, e});
    end
    chk({tag, "_excl"}, {29'd0, pc_write & pc_write_cond, mem_read & mem_write, reg_write & ir_write}, 32'd0);
  endtask
  task automatic run(input string tag, input logic [31:0] x, input int n);
    @(posedge clk);
    #1;
    inst = x;
    rst = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(posedge clk);
      step($sformatf("%s_c%0d", tag, k));
    end
  endtask
  logic [17:0] RST, F, D, DJ, MA, MR, MWB, MW, RWB, IWB, BR, JP, JRS;
  initial begin
    RST = cw(2'b00, 0, 0, 2'b00, A_ADD, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    F   = cw(2'b00, 0, 0, 2'b01, A_ADD, 2'b00, 1, 0, 0, 1, 0, 1, 0);
    D   = cw(2'b00, 0, 0, 2'b11, A_ADD, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    DJ  = cw(2'b10, 0, 0, 2'b11, A_ADD, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    MA  = cw(2'b00, 0, 1, 2'b10, A_ADD, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    MR  = cw(2'b00, 0, 0, 2'b00, A_ADD, 2'b00, 0, 0, 1, 0, 0, 1, 0);
    MWB = cw(2'b00, 1, 0, 2'b00, A_ADD, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    MW  = cw(2'b00, 0, 0, 2'b00, A_ADD, 2'b00, 0, 0, 1, 0, 0, 0, 1);
    RWB = cw(2'b01, 0, 0, 2'b00, A_ADD, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    IWB = cw(2'b00, 0, 0, 2'b00, A_ADD, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    BR  = cw(2'b00, 0, 1, 2'b00, A_SUB, 2'b10, 0, 1, 0, 0, 0, 0, 0);
    JP  = cw(2'b00, 0, 0, 2'b00, A_ADD, 2'b01, 1, 0, 0, 0, 0, 0, 0);
    JRS = cw(2'b00, 0, 0, 2'b00, A_ADD, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      push(RST);
      @(posedge clk);
      step($sformatf("reset_c%0d", k));
    end
    push(F); push(D); push(MA); push(MR); push(MWB);
    run("lw", 32'h8C220004, 5);
    push(F); push(D); push(cw(2'b00, 0, 1, 2'b00, A_ADD, 2'b00, 0, 0, 0, 0, 0, 0, 0)); push(RWB);
    run("add", 32'h00430820, 4);
    push(F); push(D); push(cw(2'b00, 0, 1, 2'b00, A_SLT, 2'b00, 0, 0, 0, 0, 0, 0, 0)); push(RWB);
    run("slt", 32'h0043082A, 4);
    push(F); push(D); push(cw(2'b00, 0, 1, 2'b00, A_SUB, 2'b00, 0, 0, 0, 0, 0, 0, 0)); push(RWB);
    run("sub", 32'h00430822, 4);
    push(F); push(D); push(cw(2'b00, 0, 1, 2'b00, A_AND, 2'b00, 0, 0, 0, 0, 0, 0, 0)); push(RWB);
    run("and", 32'h00430824, 4);
    push(F); push(D); push(cw(2'b00, 0, 1, 2'b00, A_OR, 2'b00, 0, 0, 0, 0, 0, 0, 0)); push(RWB);
    run("or", 32'h00430825, 4);
    push(F); push(D); push(cw(2'b00, 0, 1, 2'b00, A_ADD, 2'b00, 0, 0, 0, 0, 0, 0, 0)); push(RWB);
    run("rfunct_unk", 32'h0043083F, 4);
    push(F); push(D); push(cw(2'b00, 0, 1, 2'b10, A_ADD, 2'b00, 0, 0, 0, 0, 0, 0, 0)); push(IWB);
    run("addi", 32'h20220005, 4);
    push(F); push(D); push(cw(2'b00, 0, 1, 2'b10, A_SLT, 2'b00, 0, 0, 0, 0, 0, 0, 0)); push(IWB);
    run("slti", 32'h28220005, 4);
    push(F); push(D); push(MA); push(MW);
    run("sw", 32'hAC220004, 4);
    push(F); push(D); push(BR);
    run("beq", 32'h10220003, 3);
    push(F); push(D); push(JP);
    run("j", 32'h08000010, 3);
    push(F); push(DJ); push(JP);
    run("jal", 32'h0C000010, 3);
    push(F); push(D); push(JRS);
    run("jr", 32'h03E00008, 3);
    push(F); push(D);
    run("unknown", 32'hFC000000, 2);
    push(F); push(D); push(MA);
    run("sw_rst", 32'hAC220004, 3);
    push(RST);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("sw_rst_memwrite");
    chk("sw_rst_mem_write", {31'd0, mem_write}, 32'd0);
    push(F); push(D); push(cw(2'b00, 0, 1, 2'b00, A_ADD, 2'b00, 0, 0, 0, 0, 0, 0, 0)); push(RWB);
    run("add_after_rst", 32'h00430820, 4);
    push(F);
    run("tail_fetch", 32'h00430820, 1);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
